// File: rtl/magic_ctrl_pkg.sv
// rtl/magic_ctrl_pkg.sv - shared types and constants for the magic-mode controller
package common;

  // CPU bus snapshot seen by the controller each clk28 cycle
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        mreq;
    logic        ioreq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic        mreq_rise;
  } cpu_bus_t;

  typedef logic [2:0] magic_state_t;

  localparam magic_state_t ST_IDLE    = 3'd0;
  localparam magic_state_t ST_PEND    = 3'd1;
  localparam magic_state_t ST_SIG     = 3'd2;
  localparam magic_state_t ST_MAPPED  = 3'd3;
  localparam magic_state_t ST_UNMAP   = 3'd4;
  localparam magic_state_t ST_REENTER = 3'd5;

  // NMI request source bit positions (bit 0 wins priority)
  localparam int MAGIC_SRC_BUTTON  = 0;
  localparam int MAGIC_SRC_PAUSE   = 1;
  localparam int MAGIC_SRC_FASTFWD = 2;

endpackage

// File: rtl/magic_cfg_regs.sv
// rtl/magic_cfg_regs.sv - magic config register file with registered read-back
module magic_cfg_regs #(
  parameter int                   NREGS    = 19,
  parameter logic [NREGS*8-1:0]   CFG_INIT = '0
) (
  input  logic               clk28,
  input  logic               rst_n,
  input  logic               we,
  input  logic               re,
  input  logic [7:0]         idx,
  input  logic [7:0]         wdata,
  input  logic [7:0]         status,
  output logic [NREGS*8-1:0] cfg,
  output logic [7:0]         d_out,
  output logic               d_out_active
);

  // Register 0 is the status byte supplied by the owner; only 1..NREGS-1 are stored here
  logic [(NREGS-1)*8-1:0] regs_q;
  logic [7:0]             rd_byte;
  logic                   in_range;

  assign in_range = ({24'd0, idx} < NREGS);
  assign cfg      = {regs_q, status};

  // Read-back mux over the full flattened image
  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == 8'(i)) rd_byte = cfg[i*8 +: 8];
    end
  end

  // Store writes to indices 1..NREGS-1; out-of-range indices fall through every compare
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= CFG_INIT[NREGS*8-1:8];
    end else if (we) begin
      for (int i = 1; i < NREGS; i++) begin
        if (idx == 8'(i)) regs_q[(i-1)*8 +: 8] <= wdata;
      end
    end
  end

  // Registered read data and bus drive enable
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      d_out        <= '0;
      d_out_active <= 1'b0;
    end else begin
      d_out_active <= re & in_range;
      d_out        <= (re & in_range) ? rd_byte : 8'h00;
    end
  end

endmodule

// File: rtl/magic_ctrl.sv
// rtl/magic_ctrl.sv - NMI-driven magic mode controller with signature check and config regs
module magic_ctrl
  import common::*;
#(
  parameter int                 NSRC           = 3,
  parameter int                 NREGS          = 19,
  parameter int                 SIG_LEN        = 2,
  parameter logic [7:0]         SIG_OPCODE     = 8'hEB,
  parameter logic [15:0]        NMI_VEC        = 16'h0066,
  parameter logic [15:0]        EXIT_ADDR      = 16'hF000,
  parameter logic [15:0]        REENTER_ADDR   = 16'hF008,
  parameter int                 MAGIC_ON_START = 1,
  parameter logic [NREGS*8-1:0] CFG_INIT       = '0
) (
  input  logic               clk28,
  input  logic               rst_n,
  input  cpu_bus_t           bus,
  input  logic               n_int,
  input  logic               n_int_next,
  input  logic [NSRC-1:0]    nmi_req,
  output logic               n_nmi,
  output logic               magic_mode,
  output logic               magic_map,
  output logic [NREGS*8-1:0] cfg,
  output logic [7:0]         d_out,
  output logic               d_out_active
);

  localparam magic_state_t ENTRY_STATE = (SIG_LEN == 0) ? ST_MAPPED : ST_SIG;
  localparam logic         START_ON    = (MAGIC_ON_START != 0);

  magic_state_t    state_q;
  logic [1:0]      sig_cnt_q;
  logic            sig_arm_q;
  logic            sig_ok_q;
  logic            reent_q;
  logic [NSRC-1:0] cause_q;
  logic [NSRC-1:0] set_mask;
  logic [NSRC-1:0] clr_mask;
  logic            nmi_event;
  logic            cs;
  logic            fetch;
  logic            mem_rd;
  logic            sig_match;

  assign nmi_event = n_int & ~n_int_next & (|nmi_req);
  assign cs        = magic_map & bus.ioreq & (bus.a[7:0] == 8'hFF);
  assign fetch     = bus.m1 & bus.mreq & bus.rd;
  assign mem_rd    = bus.mreq & bus.rd;
  assign sig_match = fetch & (bus.d == SIG_OPCODE);

  // Cause set/clear masks; set is OR-ed after clear so a simultaneous event wins
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (nmi_event) set_mask = nmi_req;
    if (cs && bus.wr && bus.a[15:8] == 8'h00) clr_mask = bus.d[NSRC-1:0];
  end

  // Cause latch
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) cause_q <= '0;
    else        cause_q <= (cause_q & ~clr_mask) | set_mask;
  end

  // Magic mode sequencer: NMI entry, signature check, exit/reentry unmapping
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= START_ON ? ENTRY_STATE : ST_IDLE;
      sig_cnt_q  <= START_ON ? 2'(SIG_LEN) : 2'd0;
      sig_arm_q  <= 1'b0;
      sig_ok_q   <= 1'b0;
      reent_q    <= 1'b0;
      n_nmi      <= 1'b1;
      magic_mode <= START_ON;
      magic_map  <= START_ON;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (nmi_event) begin
            n_nmi      <= 1'b0;
            magic_mode <= 1'b1;
            state_q    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (bus.m1 && bus.mreq_rise && bus.a == NMI_VEC) begin
            n_nmi     <= 1'b1;
            magic_map <= 1'b1;
            sig_cnt_q <= 2'(SIG_LEN);
            sig_arm_q <= 1'b0;
            state_q   <= ENTRY_STATE;
          end
        end
        ST_SIG: begin
          // Only fetches that start inside SIG are judged; the entry fetch itself is not
          if (sig_cnt_q == 2'd0) begin
            state_q <= ST_MAPPED;
          end else if (sig_arm_q && !bus.mreq) begin
            sig_arm_q <= 1'b0;
            if (sig_ok_q) begin
              sig_cnt_q <= sig_cnt_q - 2'd1;
              if (sig_cnt_q == 2'd1) state_q <= ST_MAPPED;
            end else begin
              magic_mode <= 1'b0;
              magic_map  <= 1'b0;
              sig_cnt_q  <= 2'd0;
              state_q    <= ST_IDLE;
            end
          end else if (bus.m1 && bus.mreq_rise) begin
            sig_arm_q <= 1'b1;
            sig_ok_q  <= sig_match;
          end else if (sig_arm_q && fetch) begin
            sig_ok_q <= sig_match;
          end
        end
        ST_MAPPED: begin
          if (mem_rd && bus.a == EXIT_ADDR) begin
            magic_mode <= 1'b0;
            reent_q    <= 1'b0;
            state_q    <= ST_UNMAP;
          end else if (mem_rd && bus.a == REENTER_ADDR) begin
            reent_q <= 1'b1;
            state_q <= ST_UNMAP;
          end
        end
        ST_UNMAP: begin
          if (!bus.mreq) begin
            magic_map <= 1'b0;
            state_q   <= reent_q ? ST_REENTER : ST_IDLE;
          end
        end
        ST_REENTER: begin
          if (bus.m1 && bus.mreq_rise) begin
            magic_map <= 1'b1;
            sig_cnt_q <= 2'd0;
            sig_arm_q <= 1'b0;
            state_q   <= ENTRY_STATE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  magic_cfg_regs #(
    .NREGS    (NREGS),
    .CFG_INIT (CFG_INIT)
  ) u_regs (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .we           (cs & bus.wr),
    .re           (cs & bus.rd),
    .idx          (bus.a[15:8]),
    .wdata        (bus.d),
    .status       (8'(cause_q)),
    .cfg          (cfg),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

endmodule

// File: tb/tb_magic_ctrl.sv
// tb/tb_magic_ctrl.sv - directed self-checking bench for magic_ctrl
module tb_magic_ctrl;
  import common::*;

  logic           clk28;
  logic           rst_n;
  cpu_bus_t       bus;
  logic           n_int;
  logic           n_int_next;
  logic [2:0]     nmi_req;
  logic           n_nmi;
  logic           magic_mode;
  logic           magic_map;
  logic [151:0]   cfg;
  logic [7:0]     d_out;
  logic           d_out_active;
  logic [151:0]   exp_cfg;
  int             checks;
  int             errors;

  magic_ctrl dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bus          (bus),
    .n_int        (n_int),
    .n_int_next   (n_int_next),
    .nmi_req      (nmi_req),
    .n_nmi        (n_nmi),
    .magic_mode   (magic_mode),
    .magic_map    (magic_map),
    .cfg          (cfg),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus_idle();
    bus        = '0;
    n_int      = 1'b1;
    n_int_next = 1'b1;
    nmi_req    = '0;
  endtask

  task automatic m1_fetch(input logic [15:0] addr, input logic [7:0] data);
    bus.a = addr; bus.d = data; bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1; bus.mreq_rise = 1'b1;
    step();
    bus.mreq_rise = 1'b0;
    step();
    bus_idle();
    step();
  endtask

  task automatic nmi_event(input logic [2:0] req);
    n_int = 1'b1; n_int_next = 1'b0; nmi_req = req;
    step();
    bus_idle();
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
    bus.a = addr; bus.d = data; bus.ioreq = 1'b1; bus.wr = 1'b1;
    step();
    bus_idle();
    step();
  endtask

  task automatic io_read(input logic [15:0] addr, output logic [7:0] data, output logic act);
    bus.a = addr; bus.ioreq = 1'b1; bus.rd = 1'b1;
    step();
    data = d_out;
    act  = d_out_active;
    bus_idle();
    step();
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL reset_n_nmi got %b want 1", n_nmi); end
    checks++; if (magic_mode !== 1'b1 || magic_map !== 1'b1) begin errors++; $display("FAIL reset_mode_map got %b%b want 11", magic_mode, magic_map); end
    checks++; if (d_out_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", d_out_active); end
    checks++; if (cfg !== 152'd0) begin errors++; $display("FAIL reset_cfg got %h want 0", cfg); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_bad_signature();
    bus.a = 16'h0000; bus.d = 8'h00; bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1; bus.mreq_rise = 1'b1;
    step();
    bus.mreq_rise = 1'b0;
    step();
    checks++; if (magic_mode !== 1'b1) begin errors++; $display("FAIL badsig_mode_during_read got %b want 1", magic_mode); end
    bus_idle();
    step();
    checks++; if (magic_mode !== 1'b0 || magic_map !== 1'b0) begin errors++; $display("FAIL badsig_mode_map got %b%b want 00", magic_mode, magic_map); end
  endtask

  task automatic test_button();
    logic [7:0] rd; logic act;
    nmi_event(3'b001);
    checks++; if (n_nmi !== 1'b0 || magic_mode !== 1'b1) begin errors++; $display("FAIL button_nmi got n_nmi=%b mode=%b want 0,1", n_nmi, magic_mode); end
    m1_fetch(16'h0038, 8'hEB);
    checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL button_wrong_vec got %b want 0", n_nmi); end
    m1_fetch(16'h0066, 8'hF5);
    checks++; if (n_nmi !== 1'b1 || magic_map !== 1'b1) begin errors++; $display("FAIL button_vec got n_nmi=%b map=%b want 1,1", n_nmi, magic_map); end
    m1_fetch(16'h0067, 8'hEB);
    m1_fetch(16'h0068, 8'hEB);
    io_read(16'h00FF, rd, act);
    checks++; if (rd !== 8'h01 || act !== 1'b1) begin errors++; $display("FAIL button_status got %h/%b want 01/1", rd, act); end
    checks++; if (cfg[7:0] !== 8'h01) begin errors++; $display("FAIL button_cfg0 got %h want 01", cfg[7:0]); end
  endtask

  task automatic test_registers();
    logic [7:0] rd; logic act;
    exp_cfg = 152'd0;
    exp_cfg[7:0] = 8'h01;
    io_write(16'h05FF, 8'hA5);
    exp_cfg[47:40] = 8'hA5;
    checks++; if (cfg !== exp_cfg) begin errors++; $display("FAIL reg_write5 got %h want %h", cfg, exp_cfg); end
    io_read(16'h05FF, rd, act);
    checks++; if (rd !== 8'hA5 || act !== 1'b1) begin errors++; $display("FAIL reg_read5 got %h/%b want a5/1", rd, act); end
    io_write(16'h40FF, 8'h5A);
    checks++; if (cfg !== exp_cfg) begin errors++; $display("FAIL reg_write_oob got %h want %h", cfg, exp_cfg); end
    io_read(16'h40FF, rd, act);
    checks++; if (act !== 1'b0 || rd !== 8'h00) begin errors++; $display("FAIL reg_read_oob got %h/%b want 00/0", rd, act); end
    io_write(16'h12FF, 8'h3C);
    exp_cfg[151:144] = 8'h3C;
    checks++; if (cfg !== exp_cfg) begin errors++; $display("FAIL reg_write18 got %h want %h", cfg, exp_cfg); end
    io_read(16'h13FF, rd, act);
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL reg_read19 got %b want 0", act); end
  endtask

  task automatic test_priority_w1c();
    n_int = 1'b1; n_int_next = 1'b0; nmi_req = 3'b010;
    bus.a = 16'h00FF; bus.d = 8'h02; bus.ioreq = 1'b1; bus.wr = 1'b1;
    step();
    bus_idle();
    checks++; if (cfg[7:0] !== 8'h03) begin errors++; $display("FAIL w1c_set_wins got %h want 03", cfg[7:0]); end
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL w1c_no_nmi_when_busy got %b want 1", n_nmi); end
    io_write(16'h00FF, 8'h01);
    checks++; if (cfg[7:0] !== 8'h02) begin errors++; $display("FAIL w1c_clear0 got %h want 02", cfg[7:0]); end
    io_write(16'h00FF, 8'h02);
    checks++; if (cfg[7:0] !== 8'h00) begin errors++; $display("FAIL w1c_clear1 got %h want 00", cfg[7:0]); end
  endtask

  task automatic test_exit();
    bus.a = 16'hF000; bus.mreq = 1'b1; bus.rd = 1'b1;
    step();
    checks++; if (magic_mode !== 1'b0 || magic_map !== 1'b1) begin errors++; $display("FAIL exit_read got mode=%b map=%b want 0,1", magic_mode, magic_map); end
    step();
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL exit_hold_map got %b want 1", magic_map); end
    bus_idle();
    step();
    checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL exit_unmap got %b want 0", magic_map); end
  endtask

  task automatic test_reentry();
    nmi_event(3'b100);
    checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL reent_nmi got %b want 0", n_nmi); end
    m1_fetch(16'h0066, 8'h00);
    m1_fetch(16'h0067, 8'hEB);
    m1_fetch(16'h0068, 8'hEB);
    bus.a = 16'hF008; bus.mreq = 1'b1; bus.rd = 1'b1;
    step();
    bus_idle();
    step();
    checks++; if (magic_map !== 1'b0 || magic_mode !== 1'b1) begin errors++; $display("FAIL reent_unmap got map=%b mode=%b want 0,1", magic_map, magic_mode); end
    m1_fetch(16'h8000, 8'h00);
    checks++; if (magic_map !== 1'b1 || magic_mode !== 1'b1) begin errors++; $display("FAIL reent_map got map=%b mode=%b want 1,1", magic_map, magic_mode); end
    m1_fetch(16'h8001, 8'h00);
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL reent_nosig got %b want 1", magic_map); end
    bus.a = 16'hF000; bus.mreq = 1'b1; bus.rd = 1'b1;
    step();
    bus_idle();
    checks++; if (magic_mode !== 1'b0) begin errors++; $display("FAIL reent_mapped_exit got %b want 0", magic_mode); end
    step();
  endtask

  task automatic test_reset_mid_nmi();
    nmi_event(3'b001);
    checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL midrst_pend got %b want 0", n_nmi); end
    rst_n = 1'b0;
    #1;
    checks++; if (n_nmi !== 1'b1 || cfg[7:0] !== 8'h00) begin errors++; $display("FAIL midrst_async got n_nmi=%b cause=%h want 1,00", n_nmi, cfg[7:0]); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus_idle();
    test_reset();
    test_bad_signature();
    test_button();
    test_registers();
    test_priority_w1c();
    test_exit();
    test_reentry();
    test_reset_mid_nmi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/magic_ctrl.md
MAGIC_CTRL -- requirements
Module: magic_ctrl

Interface
REQ-001 Parameter NSRC, default 3: number of NMI request sources, range 1..8.
REQ-002 Parameter NREGS, default 19: config register count, range 2..64; index 0 is status.
REQ-003 Parameter SIG_LEN, default 2: number of opcode-signature fetches checked after NMI entry, range 0..3.
REQ-004 Parameter SIG_OPCODE, default 8'hEB: required signature opcode.
REQ-005 Parameters NMI_VEC 16'h0066, EXIT_ADDR 16'hF000, REENTER_ADDR 16'hF008: entry, exit and exit-with-reentry addresses.
REQ-006 Parameter MAGIC_ON_START, default 1: enter magic mode out of reset.
REQ-007 Parameter CFG_INIT, default all zero, width NREGS*8: reset image of the config registers.
REQ-008 clk28  in  1  system clock.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 bus  cpu_bus  -  CPU bus (a, d, mreq, ioreq, m1, rd, wr, mreq_rise).
REQ-011 n_int, n_int_next  in  1,1  current and next-cycle INT level.
REQ-012 nmi_req  in  NSRC  level NMI requests; bit 0 is highest priority.
REQ-013 n_nmi  out  1  NMI to CPU, active low.
REQ-014 magic_mode, magic_map  out  1,1  magic mode active; magic ROM/RAM mapped.
REQ-015 cfg  out  NREGS*8  flattened config registers; byte i is register i.
REQ-016 d_out, d_out_active  out  8,1  read-back data and drive enable.

Function
REQ-017 An NMI event is a cycle with n_int=1, n_int_next=0 and any nmi_req bit set.
REQ-018 Requests are sampled only on NMI event cycles.
REQ-019 On an NMI event, the cause latch ORs in nmi_req regardless of state.
REQ-020 Cause is readable as status bits [NSRC-1:0].
REQ-021 FSM states: IDLE, PEND, SIG, MAPPED, UNMAP, REENTER.
REQ-022 IDLE to PEND on an NMI event: n_nmi<=0, magic_mode<=1.
REQ-023 An NMI event while not in IDLE only updates the cause latch; n_nmi stays high.
REQ-024 PEND: on an M1 cycle with mreq_rise and a==NMI_VEC: n_nmi<=1, magic_map<=1, signature counter<=SIG_LEN, go to SIG (MAPPED if SIG_LEN=0).
REQ-025 SIG: each M1 memory read compares d to SIG_OPCODE at that cycle; the result is applied when the read ends.
REQ-026 SIG on match: decrement the counter; go to MAPPED at zero.
REQ-027 SIG on mismatch: magic_mode<=0, magic_map<=0, counter<=0, go to IDLE.
REQ-028 MAPPED: memory read at EXIT_ADDR sets magic_mode<=0 and goes to UNMAP.
REQ-029 MAPPED: memory read at REENTER_ADDR goes to UNMAP with reenter flag set.
REQ-030 UNMAP: on the first cycle with mreq=0, magic_map<=0; go to REENTER if the flag is set, else IDLE.
REQ-031 REENTER: on the next M1 mreq_rise at any address, magic_map<=1 and go to SIG, or MAPPED if SIG_LEN=0.
REQ-032 REENTER entry skips the signature check: counter<=0.
REQ-033 Config select cs is magic_map & ioreq & a[7:0]==8'hFF; register index is a[15:8].
REQ-034 A write with index 1..NREGS-1 stores d into that register one clk28 after wr is seen.
REQ-035 Writes with index >= NREGS are ignored.
REQ-036 A write with index 0 clears the cause bits set in d[NSRC-1:0] (write-1-to-clear).
REQ-037 If an NMI event and a clear hit the same cause bit in one cycle, the set wins.
REQ-038 Reads with index < NREGS drive that register one clk28 after rd is seen.
REQ-039 Register 0 reads as {zero fill, cause}.
REQ-040 d_out_active is registered cs & rd & index<NREGS; it is 0 otherwise.
REQ-041 cfg byte 0 mirrors cause, zero-extended.

Reset
REQ-042 On rst_n low: n_nmi=1, magic_mode=magic_map=MAGIC_ON_START, cause=0, d_out_active=0, cfg bytes 1..NREGS-1=CFG_INIT.
REQ-043 On rst_n low: FSM=SIG with counter=SIG_LEN if MAGIC_ON_START (MAPPED if SIG_LEN=0), else IDLE.
REQ-044 Reset mid-operation abandons any pending NMI or unmap immediately.

Structure
REQ-045 magic_state_t and the NMI source index constants (MAGIC_SRC_BUTTON=0, PAUSE=1, FASTFWD=2) live in package common.
REQ-046 The register file with read-back mux is sub-module magic_cfg_regs, parameterised by NREGS and CFG_INIT.

Verification
REQ-047 Button: nmi_req=3'b001 at INT fall -> n_nmi=0; M1 fetch 0066 -> n_nmi=1, map=1; fetches EB,EB -> MAPPED; status read=8'h01.
REQ-048 Bad signature: after reset, first M1 fetch returns 8'h00 -> magic_mode=0, magic_map=0 at read end, FSM IDLE.
REQ-049 Exit: MAPPED, read F000 -> mode=0 at once; map=0 on first mreq=0.
REQ-050 Reentry: read F008 then mreq=0 -> map=0; next M1 at 8000 -> map=1 without signature check.
REQ-051 Registers: OUT (0x05FF),8'hA5 -> cfg[47:40]=A5; IN 0x05FF -> d_out=A5, active=1; index 0x40 with NREGS=19 -> no write, active=0.
REQ-052 Priority/W1C: write 0x00FF,8'h02 in the NMI-event cycle with nmi_req=3'b010 -> cause bit1 remains 1.
